// File: rtl/instruction_encoder.sv
// instruction_encoder
// Packs RV32I fields plus a 32-bit immediate into a 32-bit instruction word.
// The combinational encoder feeds a 2-entry output FIFO of {instr, err}
// with valid/ready handshakes on both sides. Immediates that do not fit the
// instruction format (range or alignment) set err, and the word is still
// delivered with the truncated encoding. Delivered words and delivered
// errors are counted (wrapping and saturating respectively).

module instruction_encoder (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // field source side
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    // instruction sink side
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    // statistics
    output logic [15:0] count_o,
    output logic [7:0]  err_count_o
);

    // ------------------------------------------------------------------
    // RV32I major opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;

    // One buffered word: the encoding and the error flag that travels with it
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    // ------------------------------------------------------------------
    // Immediate range checks: a value fits an N-bit signed field when all
    // bits from the sign bit upward are identical.
    // ------------------------------------------------------------------
    logic imm_fits_12;   // I/S: imm[31:11] all equal
    logic imm_fits_13;   // B:   imm[31:12] all equal
    logic imm_fits_21;   // J:   imm[31:20] all equal
    logic is_shift_imm;  // slli/srli/srai carry a 5-bit shamt

    assign imm_fits_12  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign imm_fits_13  = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign imm_fits_21  = (&imm_i[31:20]) | ~(|imm_i[31:20]);
    assign is_shift_imm = (opcode_i == OP_IMM) &&
                          ((funct3_i == F3_SLLI) || (funct3_i == F3_SRXI));

    // ------------------------------------------------------------------
    // Encoder: place fields by instruction format and flag bad immediates
    // ------------------------------------------------------------------
    entry_t enc;

    // Combinational field packing for the word offered on the input side
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        enc = '0;
        case (opcode_i)
            OP_R: begin
                enc.instr = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
                enc.err   = 1'b0;
            end
            OP_LOAD, OP_JALR, OP_IMM: begin
                if (is_shift_imm) begin
                    enc.instr = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc.err   = |imm_i[31:5];
                end else begin
                    enc.instr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    enc.err   = ~imm_fits_12;
                end
            end
            OP_STORE: begin
                enc.instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc.err   = ~imm_fits_12;
            end
            OP_BRANCH: begin
                enc.instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
                enc.err   = ~imm_fits_13 | imm_i[0];
            end
            OP_JAL: begin
                enc.instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                             rd_i, opcode_i};
                enc.err   = ~imm_fits_21 | imm_i[0];
            end
            OP_LUI, OP_AUIPC: begin
                enc.instr = {imm_i[31:12], rd_i, opcode_i};
                enc.err   = |imm_i[11:0];
            end
            default: begin
                // Unknown opcode: no meaningful encoding exists
                enc.instr = 32'h0000_0000;
                enc.err   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO: head_q is always the word presented on instr_o/err_o,
    // tail_q holds the second word when two are buffered. A pop shifts the
    // tail forward, so the presented word never moves while stalled.
    // ------------------------------------------------------------------
    entry_t      head_q, head_d;
    entry_t      tail_q, tail_d;
    logic [1:0]  occ_q, occ_d;
    logic        ready_q, ready_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        push;
    logic        pop;

    assign push = valid_i && ready_q;
    assign pop  = (occ_q != 2'd0) && ready_i;

    // Next-state for buffer contents, occupancy and the registered ready
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = enc;
                end else begin
                    tail_d = enc;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: the new word lands behind whatever
                // remains after the pop.
                if (occ_q == 2'd1) begin
                    head_d = enc;
                end else begin
                    head_d = tail_q;
                    tail_d = enc;
                end
            end
            default: ;
        endcase
        ready_d = (occ_d != 2'd2);
    end

    // Next-state for the delivery counters (wrapping / saturating)
    always_comb begin
        count_d     = count_q;
        err_count_d = err_count_q;
        if (pop) begin
            count_d = count_q + 16'd1;
            if (head_q.err && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State registers; reset empties the buffer and clears the counters
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the buffer storage is reset too, because instr_o/err_o
            // are read straight from head_q and must show zero out of reset.
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= 2'd0;
            ready_q     <= 1'b1;
            count_q     <= 16'd0;
            err_count_q <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = (occ_q != 2'd0);
    assign instr_o     = head_q.instr;
    assign err_o       = head_q.err;
    assign count_o     = count_q;
    assign err_count_o = err_count_q;

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs RV32I instruction fields plus a 32-bit immediate into a 32-bit instruction word, the inverse of the core's immediate decoding. It sits in the test/boot infrastructure between a field source (program loader, random instruction generator) and instruction memory or the fetch stage. Input and output use valid/ready handshakes with a 2-entry output buffer. Out-of-range or misaligned immediates are flagged per instruction and counted.

## Interface
- No parameters.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  input fields valid.
- ready_o  output  1  encoder can accept; registered.
- opcode_i  input  7  opcode.
- rd_i, rs1_i, rs2_i  input  5 each  register indices.
- funct3_i  input  3  funct3.
- funct7_i  input  7  funct7; also the upper bits for shift-immediates.
- imm_i  input  32  immediate as a signed byte offset/value.
- valid_o  output  1  encoded word available.
- ready_i  input  1  consumer accepts.
- instr_o  output  32  encoded instruction (head of buffer).
- err_o  output  1  error flag travelling with instr_o.
- count_o  output  16  delivered-instruction counter; wraps.
- err_count_o  output  8  delivered-with-error counter; saturates at 255.

## Operation
- Field placement: rd [11:7] (R,I,U,J); funct3 [14:12] (R,I,S,B); rs1 [19:15] (R,I,S,B); rs2 [24:20] (R,S,B); opcode [6:0]. Unused fields are 0.
- R (0110011): [31:25]=funct7_i; imm_i ignored; err=0.
- I (0000011, 1100111, 0010011):
  - For 0010011 with funct3 001/101: [31:25]=funct7_i, [24:20]=imm_i[4:0]; err if imm_i[31:5]!=0.
  - Otherwise [31:20]=imm_i[11:0]; err if imm_i[31:11] is not all-equal.
- S (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0]; same 12-bit signed range check.
- B (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; err if imm_i[31:12] is not all-equal or imm_i[0]=1.
- J (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; err if imm_i[31:20] is not all-equal or imm_i[0]=1.
- U (0110111, 0010111): [31:12]=imm_i[31:12]; err if imm_i[11:0]!=0.
- Any other opcode: instr=0, err=1.
- On error, the word is still the truncated encoding (except unknown opcode) and is delivered normally.
- Buffer is a 2-entry FIFO of {instr, err}. Push = valid_i && ready_o; pop = valid_o && ready_i.
- Counters increment on pop; err_count_o increments only when the popped err=1.

## Timing
- Reset (async assert, sync deassert use): ready_o=1, valid_o=0, instr_o=0, err_o=0, count_o=0, err_count_o=0; buffer emptied.
- Latency: a word accepted at edge N is presented at edge N when the buffer is empty (valid_o high in cycle N+1). Encoding is combinational ahead of the buffer write.
- ready_o is registered: 1 when occupancy after the edge is <2. Full (2) drops ready_o; the first pop re-raises it at the next edge.
- Push and pop in the same cycle leave occupancy unchanged. At occupancy 2 the push is blocked because ready_o=0.
- valid_o, instr_o and err_o are held stable while valid_o=1 and ready_i=0.
- Strict FIFO order. No drops, no duplicates.
- count_o goes 0xFFFF→0x0000. err_count_o holds at 0xFF.
- Reset asserted mid-stream discards buffered words immediately; counters clear.

## Test plan
- addi x1,x0,5 (0010011, rd=1, funct3=0, imm=5) with ready_i=1 -> instr_o=0x00500093, err_o=0, valid_o high one cycle after acceptance, count_o=1.
- sw x2,8(x1) -> 0x0020A423. beq x0,x0,-4 (imm=0xFFFFFFFC) -> 0xFE000EE3. jal x1,2048 -> 0x001000EF. lui x5,0x12345000 -> 0x123452B7. All with err_o=0.
- Errors: addi imm=2048 -> err_o=1; beq imm=3 -> err_o=1; lui imm=0x12345001 -> err_o=1; opcode 0x7F -> instr_o=0, err_o=1; err_count_o=4 after delivery.
- Backpressure: ready_i=0 with 3 pushes offered -> 2 accepted, ready_o=0, third held. Then ready_i=1 -> all 3 delivered in order, with instr_o stable while stalled.
- Simultaneous push/pop at occupancy 1 with continuous streaming of 10 words -> ready_o stays 1, 10 words in order, count_o=10.
- Reset asserted with 2 words buffered -> valid_o=0, ready_o=1, counters 0 immediately. First post-reset word encodes correctly.
